audio_pcm_out: RTL and testbench
================================

AUDIO_PCM_OUT -- requirements
Module: audio_pcm_out

Interface
REQ-001 SHALL have parameter DW, default 32, Wishbone data width; only 32 is supported.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, sample FIFO entries (power of 2).
REQ-003 SHALL have port clk  input  1  system clock (24 MHz); all logic in this domain.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port wb_addr  input  2  register select.
REQ-006 SHALL have port wb_rdata  output  DW  read data.
REQ-007 SHALL have port wb_wdata  input  DW  write data.
REQ-008 SHALL have port wb_we  input  1  write strobe.
REQ-009 SHALL have port wb_cyc  input  1  cycle/select.
REQ-010 SHALL have port wb_ack  output  1  acknowledge.
REQ-011 SHALL have port usb_sof  input  1  one-clk USB start-of-frame pulse.
REQ-012 SHALL have port i2s_bclk  output  1  I2S bit clock.
REQ-013 SHALL have port i2s_lrck  output  1  word select: 0 = left, 1 = right.
REQ-014 SHALL have port i2s_sdata  output  1  serial data, MSB first.

Function
REQ-015 SHALL assert wb_ack one clk after wb_cyc rises, for exactly one clk (ack <= cyc & ~ack); wb_rdata is valid while ack is high and is 0 otherwise.
REQ-016 Reg 0 CSR read SHALL give: [0] enable, [1] underrun sticky, [2] overflow sticky, [12:8] FIFO level (0..16), others 0.
REQ-017 Reg 0 write SHALL do: [0] sets enable; [1]=1 clears underrun; [2]=1 clears overflow; [3]=1 flushes the FIFO (level 0).
REQ-018 Reg 1 DATA write SHALL push {L=[31:16], R=[15:0]} (signed 16-bit); the push happens on the ack cycle only, once per access.
REQ-019 A DATA write when FIFO is full SHALL be dropped, set overflow, and leave contents unchanged.
REQ-020 Reg 1 read SHALL return 0.
REQ-021 Reg 2 DIV [7:0] SHALL set the bclk half-period to DIV+1 clk.
REQ-022 DIV writes SHALL take effect at the next frame boundary.
REQ-023 Frame = 32 bclk periods: 16 left, then 16 right; lrck and sdata SHALL change only on the bclk falling edge.
REQ-024 lrck SHALL toggle one bclk before each word's MSB (standard I2S one-bit delay).
REQ-025 At each frame boundary, the block SHALL pop one FIFO entry into the shift register; if empty, it SHALL load 0 and set underrun.
REQ-026 A pop and a push in the same clk SHALL both occur; the level is unchanged.
REQ-027 A flush coincident with a push SHALL leave level 0.
REQ-028 When enable=0: bclk, lrck and sdata SHALL be 0; bit and divider counters held at 0; no pops; no underrun.
REQ-029 Enable 0->1 SHALL start at a frame boundary with the first bclk rising edge DIV+1 clk later.
REQ-030 Enable 1->0 SHALL stop immediately; the FIFO is retained.
REQ-031 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; the level counter is one bit wider than the pointers.

Reset
REQ-032 On rst_n=0: enable=0, sticky flags=0, FIFO level 0, DIV=3, wb_ack=0, wb_rdata=0, all I2S outputs 0, SOF counters 0.

Configuration
REQ-033 With macro AUDIO_PCM_OUT_SOF_CNT_EN defined, reg 3 SHALL read [15:0] = frames popped, underrun frames included, during the last complete usb_sof interval.
REQ-034 The running count SHALL be captured and cleared on each usb_sof; a pop in the same clk as usb_sof SHALL count toward the new interval.
REQ-035 Without AUDIO_PCM_OUT_SOF_CNT_EN, reg 3 SHALL read 0, and no SOF counter logic is instantiated.

Verification
REQ-036 Reset, then read CSR -> 0x00000000; read DIV -> 0x00000003.
REQ-037 DIV=3, push 0xA5A5_0F0F, enable -> bclk period 8 clk; left word bits 1010010110100101 MSB-first after lrck falls; right word 0x0F0F; underrun stays 0 for the first frame.
REQ-038 17 DATA writes with enable=0 -> level 16, overflow=1; CSR write 0x4 -> overflow=0.
REQ-039 Enable with an empty FIFO -> sdata constantly 0, underrun=1 after the first frame boundary; CSR write 0x2 clears it.
REQ-040 Assert rst_n low mid-frame -> all outputs 0 asynchronously; after release, CSR reads 0 and DIV reads 3.
REQ-041 With the macro, DIV=0 (bclk 12 MHz → frame 64 clk), keep the FIFO fed, usb_sof every 24000 clk -> reg 3 reads 375.

Source files
------------

// File: rtl/audio_pcm_out_if.sv
// ============================================================================
// audio_pcm_out_if : Wishbone register-bus bundle for audio_pcm_out.  Rev 1.0
// ============================================================================
`default_nettype none

interface audio_pcm_out_if #(
   parameter int DW = 32
);
   logic [1:0]    wb_addr;
   logic [DW-1:0] wb_rdata;
   logic [DW-1:0] wb_wdata;
   logic          wb_we;
   logic          wb_cyc;
   logic          wb_ack;

   modport slave (
      input  wb_addr,
      input  wb_wdata,
      input  wb_we,
      input  wb_cyc,
      output wb_rdata,
      output wb_ack
   );

   modport master (
      output wb_addr,
      output wb_wdata,
      output wb_we,
      output wb_cyc,
      input  wb_rdata,
      input  wb_ack
   );
endinterface

`default_nettype wire

// File: rtl/audio_pcm_out.sv
// ============================================================================
// audio_pcm_out : Wishbone-fed stereo I2S transmitter with a sample FIFO.
// Macro AUDIO_PCM_OUT_SOF_CNT_EN adds the per-USB-frame pop counter (reg 3).
// Rev 1.0
// ============================================================================
`default_nettype none

module audio_pcm_out #(
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   audio_pcm_out_if.slave  wb,
   input  wire logic       usb_sof,
   output logic            i2s_bclk,
   output logic            i2s_lrck,
   output logic            i2s_sdata
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef logic [AW-1:0] ptr_t;
   typedef logic [AW:0]   lvl_t;
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t        state;
   state_t        state_nxt;
   logic          start;

   logic          ack_q;
   logic [DW-1:0] rdata_q;
   logic [DW-1:0] rd_mux;

   logic          enable;
   logic          en_nxt;
   logic          underrun;
   logic          overflow;
   logic [7:0]    div_reg;
   logic [7:0]    div_act;
   logic [7:0]    div_cnt;
   logic [4:0]    bit_cnt;
   logic [31:0]   shreg;

   logic [31:0]   mem [FIFO_DEPTH];
   ptr_t          wr_ptr;
   ptr_t          rd_ptr;
   lvl_t          level;

   logic          wr_stb;
   logic          csr_wr;
   logic          data_wr;
   logic          div_wr;
   logic          flush;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          fall;
   logic          frame;
   logic [31:0]   pop_word;

   // Register writes land on the ack cycle so each access acts exactly once.
   assign wr_stb   = wb.wb_cyc & wb.wb_we & ack_q;
   assign csr_wr   = wr_stb && (wb.wb_addr == 2'd0);
   assign data_wr  = wr_stb && (wb.wb_addr == 2'd1);
   assign div_wr   = wr_stb && (wb.wb_addr == 2'd2);
   assign flush    = csr_wr & wb.wb_wdata[3];
   assign en_nxt   = csr_wr ? wb.wb_wdata[0] : enable;

   assign full     = (level == lvl_t'(FIFO_DEPTH));
   assign empty    = (level == '0);
   assign push     = data_wr & ~full;
   assign fall     = (state == ST_RUN) && en_nxt && (div_cnt == div_act) && i2s_bclk;
   assign frame    = start | (fall && (bit_cnt == 5'd31));
   assign pop      = frame & ~empty;
   assign pop_word = pop ? mem[rd_ptr] : 32'h0;

   assign wb.wb_ack   = ack_q;
   assign wb.wb_rdata = rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en_nxt) begin
               state_nxt = ST_RUN;
               start     = 1'b1;
            end
         end
         ST_RUN: begin
            if (!en_nxt) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef AUDIO_PCM_OUT_SOF_CNT_EN
   logic [15:0] sof_run;
   logic [15:0] sof_last;

   // A frame coinciding with the SOF pulse belongs to the new interval.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sof_run  <= 16'd0;
         sof_last <= 16'd0;
      end else if (usb_sof) begin
         sof_last <= sof_run;
         sof_run  <= frame ? 16'd1 : 16'd0;
      end else if (frame) begin
         sof_run  <= sof_run + 16'd1;
      end
   end
`else
   logic unused_sof;
   assign unused_sof = usb_sof;
`endif

   always_comb begin
      rd_mux = '0;
      case (wb.wb_addr)
         2'd0: begin
            rd_mux[0]        = enable;
            rd_mux[1]        = underrun;
            rd_mux[2]        = overflow;
            rd_mux[8 +: AW+1] = level;
         end
         2'd2: rd_mux[7:0] = div_reg;
`ifdef AUDIO_PCM_OUT_SOF_CNT_EN
         2'd3: rd_mux[15:0] = sof_last;
`endif
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= wb.wb_cyc & ~ack_q;
         rdata_q <= (wb.wb_cyc && !ack_q) ? rd_mux : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable   <= 1'b0;
         underrun <= 1'b0;
         overflow <= 1'b0;
         div_reg  <= 8'd3;
      end else begin
         enable <= en_nxt;
         if (div_wr) begin
            div_reg <= wb.wb_wdata[7:0];
         end
         if (csr_wr && wb.wb_wdata[1]) begin
            underrun <= 1'b0;
         end
         if (frame && empty) begin
            underrun <= 1'b1;
         end
         if (csr_wr && wb.wb_wdata[2]) begin
            overflow <= 1'b0;
         end
         if (data_wr && full) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wb.wb_wdata[31:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ptr_t'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ptr_t'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + lvl_t'(1);
            2'b01:   level <= level - lvl_t'(1);
            default: level <= level;
         endcase
      end
   end

   // Slot 0 still carries the previous right LSB, hence the one-bit I2S delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_act   <= 8'd3;
         div_cnt   <= 8'd0;
         bit_cnt   <= 5'd0;
         shreg     <= 32'h0;
         i2s_bclk  <= 1'b0;
         i2s_lrck  <= 1'b0;
         i2s_sdata <= 1'b0;
      end else if (!en_nxt) begin
         div_cnt   <= 8'd0;
         bit_cnt   <= 5'd0;
         shreg     <= 32'h0;
         i2s_bclk  <= 1'b0;
         i2s_lrck  <= 1'b0;
         i2s_sdata <= 1'b0;
      end else if (start) begin
         div_act   <= div_reg;
         div_cnt   <= 8'd0;
         bit_cnt   <= 5'd0;
         shreg     <= pop_word;
         i2s_bclk  <= 1'b0;
         i2s_lrck  <= 1'b0;
         i2s_sdata <= 1'b0;
      end else if (div_cnt == div_act) begin
         div_cnt  <= 8'd0;
         i2s_bclk <= ~i2s_bclk;
         if (i2s_bclk) begin
            i2s_sdata <= shreg[31];
            if (bit_cnt == 5'd31) begin
               bit_cnt  <= 5'd0;
               i2s_lrck <= 1'b0;
               shreg    <= pop_word;
               div_act  <= div_reg;
            end else begin
               bit_cnt  <= bit_cnt + 5'd1;
               i2s_lrck <= (bit_cnt >= 5'd15);
               shreg    <= {shreg[30:0], 1'b0};
            end
         end
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_audio_pcm_out.sv
// ============================================================================
// tb_audio_pcm_out : scoreboard bench for audio_pcm_out (I2S deframing monitor).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_audio_pcm_out;

   logic clk = 1'b0;
   logic rst_n;
   logic usb_sof;
   logic i2s_bclk;
   logic i2s_lrck;
   logic i2s_sdata;

   int total = 0;
   int bad   = 0;

   logic [16:0] exp_q[$];

   bit          mon_on = 1'b0;
   bit          mon_first;
   logic        mon_bclk = 1'b0;
   logic        mon_pl = 1'b0;
   logic        mon_pd = 1'b0;
   logic        mon_lrck;
   logic [15:0] mon_word;
   logic [16:0] mon_exp;
   int          mon_bits;
   int          mon_rises;
   int          mon_period;
   int          mon_viol;
   int          mon_words;
   int          mon_last_rise;
   int          cyc_cnt = 0;

   always #5 clk = ~clk;

   audio_pcm_out_if #(.DW(32)) bif ();

   audio_pcm_out #(.DW(32), .FIFO_DEPTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb        (bif),
      .usb_sof   (usb_sof),
      .i2s_bclk  (i2s_bclk),
      .i2s_lrck  (i2s_lrck),
      .i2s_sdata (i2s_sdata)
   );

   // I2S receiver: a word ends on the bclk rise where lrck is first seen changed.
   always @(negedge clk) begin
      if (mon_on) begin
         if (i2s_bclk && !mon_bclk) begin
            if (mon_last_rise >= 0) mon_period = cyc_cnt - mon_last_rise;
            mon_last_rise = cyc_cnt;
            mon_rises++;
            mon_word = {mon_word[14:0], i2s_sdata};
            mon_bits++;
            if (i2s_lrck !== mon_lrck) begin
               if (mon_bits == 16) begin
                  mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : {mon_lrck, 16'h0000};
                  total++;
                  mon_words++;
                  if ({mon_lrck, mon_word} !== mon_exp) begin
                     bad++;
                     $display("FAIL i2s_word: got ch=%0d 0x%04h, required ch=%0d 0x%04h",
                              mon_lrck, mon_word, mon_exp[16], mon_exp[15:0]);
                  end
               end else if (!mon_first) begin
                  total++;
                  bad++;
                  $display("FAIL i2s_framing: word of %0d bits, required 16", mon_bits);
               end
               mon_first = 1'b0;
               mon_bits  = 0;
               mon_lrck  = i2s_lrck;
            end
         end
         if (!(mon_bclk && !i2s_bclk) && ((i2s_lrck !== mon_pl) || (i2s_sdata !== mon_pd))) begin
            mon_viol++;
         end
      end else begin
         mon_first     = 1'b1;
         mon_lrck      = 1'b1;
         mon_word      = 16'h0;
         mon_bits      = 0;
         mon_rises     = 0;
         mon_last_rise = -1;
         mon_viol      = 0;
      end
      mon_bclk = i2s_bclk;
      mon_pl   = i2s_lrck;
      mon_pd   = i2s_sdata;
      cyc_cnt++;
   end

   task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                          output logic [31:0] q);
      bit got;
      got = 1'b0;
      q   = 32'h0;
      @(negedge clk);
      bif.wb_addr  = a;
      bif.wb_we    = w;
      bif.wb_wdata = d;
      bif.wb_cyc   = 1'b1;
      for (int i = 0; i < 16 && !got; i++) begin
         @(negedge clk);
         if (bif.wb_ack === 1'b1) begin
            got = 1'b1;
            q   = bif.wb_rdata;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL wb_ack_timeout: no ack seen, required ack within 16 clk");
      end
      @(posedge clk);
      #1;
      bif.wb_cyc = 1'b0;
      bif.wb_we  = 1'b0;
   endtask

   task automatic wait_rises(input int n, input string tag);
      int k;
      k = 0;
      while (mon_rises < n && k < 4000) begin
         @(negedge clk);
         k++;
      end
      if (mon_rises < n) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: saw %0d bclk rises, required %0d", tag, mon_rises, n);
      end
   endtask

   task automatic test_reset();
      logic [31:0] q;
      rst_n        = 1'b0;
      usb_sof      = 1'b0;
      bif.wb_cyc   = 1'b0;
      bif.wb_we    = 1'b0;
      bif.wb_addr  = 2'd0;
      bif.wb_wdata = 32'h0;
      repeat (3) @(negedge clk);
      total++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata, bif.wb_ack} !== 4'b0 || bif.wb_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: bclk/lrck/sdata/ack=%b%b%b%b rdata=0x%08h, required all 0",
                  i2s_bclk, i2s_lrck, i2s_sdata, bif.wb_ack, bif.wb_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      wb_xfer(2'd0, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0) begin bad++; $display("FAIL reset_csr: got 0x%08h, required 0x00000000", q); end
      wb_xfer(2'd2, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h3) begin bad++; $display("FAIL reset_div: got 0x%08h, required 0x00000003", q); end
      wb_xfer(2'd1, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0) begin bad++; $display("FAIL data_read: got 0x%08h, required 0", q); end
      wb_xfer(2'd3, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0) begin bad++; $display("FAIL reset_reg3: got 0x%08h, required 0", q); end
      // Hold cyc for two clocks: ack must drop after exactly one.
      @(negedge clk);
      bif.wb_addr = 2'd2;
      bif.wb_cyc  = 1'b1;
      @(negedge clk);
      total++;
      if (bif.wb_ack !== 1'b1 || bif.wb_rdata !== 32'h3) begin
         bad++;
         $display("FAIL ack_first: ack=%b rdata=0x%08h, required ack=1 rdata=0x3", bif.wb_ack, bif.wb_rdata);
      end
      @(negedge clk);
      total++;
      if (bif.wb_ack !== 1'b0 || bif.wb_rdata !== 32'h0) begin
         bad++;
         $display("FAIL ack_pulse: ack=%b rdata=0x%08h, required ack=0 rdata=0", bif.wb_ack, bif.wb_rdata);
      end
      bif.wb_cyc = 1'b0;
   endtask

   task automatic test_overflow();
      logic [31:0] q;
      for (int i = 0; i < 17; i++) wb_xfer(2'd1, 1'b1, $urandom, q);
      wb_xfer(2'd0, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0000_1004) begin bad++; $display("FAIL overflow_set: got 0x%08h, required 0x00001004", q); end
      wb_xfer(2'd0, 1'b1, 32'h4, q);
      wb_xfer(2'd0, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0000_1000) begin bad++; $display("FAIL overflow_clear: got 0x%08h, required 0x00001000", q); end
      wb_xfer(2'd0, 1'b1, 32'h8, q);
      wb_xfer(2'd0, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0) begin bad++; $display("FAIL flush: got 0x%08h, required 0", q); end
   endtask

   task automatic test_stream();
      logic [31:0] q;
      logic [31:0] d;
      int k;
      for (int i = 0; i < 3; i++) begin
         d = (i == 0) ? 32'hA5A5_0F0F : $urandom;
         exp_q.push_back({1'b0, d[31:16]});
         exp_q.push_back({1'b1, d[15:0]});
         wb_xfer(2'd1, 1'b1, d, q);
      end
      mon_on = 1'b1;
      wb_xfer(2'd0, 1'b1, 32'h1, q);
      wb_xfer(2'd0, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0000_0201) begin bad++; $display("FAIL stream_start_csr: got 0x%08h, required 0x00000201", q); end
      k = 0;
      while (exp_q.size() > 0 && k < 4000) begin @(negedge clk); k++; end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL stream_drain: %0d words pending, required 0", exp_q.size()); end
      wb_xfer(2'd0, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0000_0003) begin bad++; $display("FAIL stream_underrun: got 0x%08h, required 0x00000003", q); end
      total++;
      if (mon_period != 8) begin bad++; $display("FAIL bclk_period: got %0d clk, required 8", mon_period); end
      total++;
      if (mon_viol != 0) begin bad++; $display("FAIL edge_align: %0d changes off bclk fall, required 0", mon_viol); end
      mon_on = 1'b0;
      wb_xfer(2'd0, 1'b1, 32'h2, q);
      total++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata} !== 3'b000) begin
         bad++;
         $display("FAIL disable_outputs: got %b%b%b, required 000", i2s_bclk, i2s_lrck, i2s_sdata);
      end
      wb_xfer(2'd0, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0) begin bad++; $display("FAIL disable_csr: got 0x%08h, required 0", q); end
   endtask

   task automatic test_underrun();
      logic [31:0] q;
      mon_words = 0;
      mon_on    = 1'b1;
      wb_xfer(2'd0, 1'b1, 32'h1, q);
      wait_rises(70, "underrun");
      total++;
      if (mon_words < 2) begin bad++; $display("FAIL underrun_words: got %0d words, required >= 2", mon_words); end
      wb_xfer(2'd0, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h3) begin bad++; $display("FAIL underrun_set: got 0x%08h, required 0x00000003", q); end
      mon_on = 1'b0;
      wb_xfer(2'd0, 1'b1, 32'h2, q);
      wb_xfer(2'd0, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0) begin bad++; $display("FAIL underrun_clear: got 0x%08h, required 0", q); end
   endtask

   task automatic test_div_change();
      logic [31:0] q;
      int r;
      wb_xfer(2'd2, 1'b1, 32'h1, q);
      mon_on = 1'b1;
      wb_xfer(2'd0, 1'b1, 32'h1, q);
      wait_rises(5, "div1");
      total++;
      if (mon_period != 4) begin bad++; $display("FAIL div1_period: got %0d clk, required 4", mon_period); end
      wb_xfer(2'd2, 1'b1, 32'h0, q);
      r = mon_rises;
      wait_rises(r + 1, "div_hold");
      total++;
      if (mon_period != 4) begin bad++; $display("FAIL div_midframe: got %0d clk, required 4", mon_period); end
      wait_rises(40, "div0");
      total++;
      if (mon_period != 2) begin bad++; $display("FAIL div0_period: got %0d clk, required 2", mon_period); end
      total++;
      if (mon_viol != 0) begin bad++; $display("FAIL div_edge_align: %0d changes off bclk fall, required 0", mon_viol); end
      mon_on = 1'b0;
      wb_xfer(2'd0, 1'b1, 32'h2, q);
   endtask

   task automatic test_sof();
      logic [31:0] q;
      wb_xfer(2'd2, 1'b1, 32'h0, q);
      for (int i = 0; i < 16; i++) wb_xfer(2'd1, 1'b1, $urandom, q);
      wb_xfer(2'd0, 1'b1, 32'h1, q);
      @(negedge clk) usb_sof = 1'b1;
      @(negedge clk) usb_sof = 1'b0;
`ifdef AUDIO_PCM_OUT_SOF_CNT_EN
      repeat (23999) @(negedge clk);
      usb_sof = 1'b1;
      @(negedge clk) usb_sof = 1'b0;
      wb_xfer(2'd3, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'd375) begin bad++; $display("FAIL sof_count: got %0d, required 375", q); end
`else
      repeat (299) @(negedge clk);
      usb_sof = 1'b1;
      @(negedge clk) usb_sof = 1'b0;
      wb_xfer(2'd3, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0) begin bad++; $display("FAIL sof_absent: got 0x%08h, required 0", q); end
`endif
      wb_xfer(2'd0, 1'b1, 32'h2, q);
   endtask

   task automatic test_async_reset();
      logic [31:0] q;
      int k;
      wb_xfer(2'd1, 1'b1, 32'hFFFF_FFFF, q);
      wb_xfer(2'd0, 1'b1, 32'h1, q);
      k = 0;
      do begin @(negedge clk); k++; end while (i2s_bclk !== 1'b1 && k < 200);
      total++;
      if (i2s_bclk !== 1'b1) begin bad++; $display("FAIL async_bclk_timeout: bclk=%b, required 1", i2s_bclk); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata, bif.wb_ack} !== 4'b0 || bif.wb_rdata !== 32'h0) begin
         bad++;
         $display("FAIL async_reset: bclk/lrck/sdata/ack=%b%b%b%b rdata=0x%08h, required all 0",
                  i2s_bclk, i2s_lrck, i2s_sdata, bif.wb_ack, bif.wb_rdata);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wb_xfer(2'd0, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h0) begin bad++; $display("FAIL post_reset_csr: got 0x%08h, required 0", q); end
      wb_xfer(2'd2, 1'b0, 32'h0, q);
      total++;
      if (q !== 32'h3) begin bad++; $display("FAIL post_reset_div: got 0x%08h, required 0x3", q); end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_overflow();
      test_stream();
      test_underrun();
      test_div_change();
      test_sof();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
